// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the instruction cache.
//   word_t          32-bit machine word
//   icache_frame_t  one cache frame: valid bit, tag, data word
//   icache_state_t  cache controller states
//   SETS / IIDX_W / ITAG_W  geometry of the direct-mapped cache (16 one-word frames)
//   RESET_PC        fetch origin after reset (not used by the cache itself)
// Address helpers take the word address (byte address bits [31:2]), so the
// ignored byte offset never enters the cache logic.
package cpu_types_pkg;

  localparam int SETS   = 16;
  localparam int IIDX_W = $clog2(SETS);
  localparam int ITAG_W = 32 - 2 - IIDX_W;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    PREFETCH = 2'd2
  } icache_state_t;

  function automatic logic [IIDX_W-1:0] idx_of(input logic [29:0] waddr);
    return waddr[IIDX_W-1:0];
  endfunction

  function automatic logic [ITAG_W-1:0] tag_of(input logic [29:0] waddr);
    return waddr[29:IIDX_W];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Frame storage for the direct-mapped instruction cache.
//   clk_i, rst_ni  clock and asynchronous active-low reset (clears valid bits only)
//   ridx_i         combinational read index
//   rframe_o       frame at ridx_i
//   we_i           write enable, sampled on the rising clock edge
//   widx_i         write index
//   wframe_i       frame written at widx_i
module icache_array
  import cpu_types_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IIDX_W-1:0] ridx_i,
  output icache_frame_t     rframe_o,
  input  logic              we_i,
  input  logic [IIDX_W-1:0] widx_i,
  input  icache_frame_t     wframe_i
);

  logic [SETS-1:0]   valid_q;
  logic [ITAG_W-1:0] tag_q  [SETS];
  word_t             data_q [SETS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= wframe_i.valid;
    end
  end

  // Tag and data carry no reset: a frame is meaningless until its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[widx_i]  <= wframe_i.tag;
      data_q[widx_i] <= wframe_i.data;
    end
  end

  always_comb begin
    rframe_o.valid = valid_q[ridx_i];
    rframe_o.tag   = tag_q[ridx_i];
    rframe_o.data  = data_q[ridx_i];
  end

endmodule

// File: rtl/icache.sv
// Per-core, direct-mapped, read-only instruction cache with one-word blocks.
// Serves datapath fetches with zero-cycle hits and blocks on a miss while it
// fetches the word from the memory controller.
//   CLK, nRST            clock, asynchronous active-low reset
//   imemREN, imemaddr    datapath fetch request and byte address ([1:0] ignored)
//   ihit, imemload       fetched word valid this cycle, and the word
//   iREN, iaddr          read request and word-aligned address to the controller
//   iwait, iload         controller stall (0 = iload valid) and fill data
//   dbg_state_o          current controller state, for observation only
// Handshake with the controller: a request is held (iREN=1, iaddr constant)
// from its first cycle until a cycle in which iwait=0; that cycle's iload is
// the fill word and the request ends on the following clock edge.
// Optional feature: define ICACHE_PREFETCH_EN to prefetch the next sequential
// word after a demand fill when it is not already cached.
module icache
  import cpu_types_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  input  logic          imemREN,
  input  word_t         imemaddr,
  output logic          ihit,
  output word_t         imemload,
  output logic          iREN,
  output word_t         iaddr,
  input  logic          iwait,
  input  word_t         iload,
  output icache_state_t dbg_state_o
);

  icache_state_t     state_q, state_d;
  word_t             miss_addr_q, miss_addr_d;
  logic [IIDX_W-1:0] ridx;
  icache_frame_t     rframe;
  icache_frame_t     wframe;
  logic              we;
  logic              tag_match;
  logic              hit;

  // The byte offset is architecturally ignored.
  logic unused_byte_off;
  assign unused_byte_off = ^imemaddr[1:0];

`ifdef ICACHE_PREFETCH_EN
  word_t next_addr;
  logic  pf_needed;
  assign next_addr = miss_addr_q + 32'd4;
`endif

  icache_array u_array (
    .clk_i    (CLK),
    .rst_ni   (nRST),
    .ridx_i   (ridx),
    .rframe_o (rframe),
    .we_i     (we),
    .widx_i   (idx_of(miss_addr_q[31:2])),
    .wframe_i (wframe)
  );

  // The single read port looks up the fetch address, except in FETCH where
  // ihit is forced low anyway and the port is free to probe the next frame
  // for the prefetch decision.
  always_comb begin
    ridx = idx_of(imemaddr[31:2]);
`ifdef ICACHE_PREFETCH_EN
    if (state_q == FETCH) ridx = idx_of(next_addr[31:2]);
`endif
  end

  assign tag_match = rframe.valid && (rframe.tag == tag_of(imemaddr[31:2]));

  always_comb begin
    hit = 1'b0;
    case (state_q)
      IDLE:     hit = imemREN && tag_match;
`ifdef ICACHE_PREFETCH_EN
      // The frame being prefetched is off limits until its fill lands.
      PREFETCH: hit = imemREN && tag_match &&
                      (idx_of(imemaddr[31:2]) != idx_of(miss_addr_q[31:2]));
`endif
      default:  hit = 1'b0;
    endcase
  end

  assign ihit     = hit;
  assign imemload = hit ? rframe.data : '0;
  assign iREN     = (state_q != IDLE);
  assign iaddr    = iREN ? miss_addr_q : '0;
  assign we       = iREN && !iwait;

  always_comb begin
    wframe.valid = 1'b1;
    wframe.tag   = tag_of(miss_addr_q[31:2]);
    wframe.data  = iload;
  end

`ifdef ICACHE_PREFETCH_EN
  // Skip the prefetch when the next word is already resident or would wrap.
  assign pf_needed = !(rframe.valid && (rframe.tag == tag_of(next_addr[31:2]))) &&
                     (miss_addr_q != 32'hFFFF_FFFC);
`endif

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit) begin
          miss_addr_d = {imemaddr[31:2], 2'b00};
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (!iwait) begin
          state_d = IDLE;
`ifdef ICACHE_PREFETCH_EN
          if (pf_needed) begin
            state_d     = PREFETCH;
            miss_addr_d = next_addr;
          end
`endif
        end
      end
      default: begin
        if (!iwait) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  assign dbg_state_o = state_q;

endmodule
